// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: drives PC write enable, next-PC select and IF/ID
// write/flush, arbitrates redirect requests and counts taken redirects.
module fetch_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 branch,
    input  logic                 jump_m,
    input  logic                 jump,
    input  logic                 stall,
    input  logic                 mem_ready,
    output logic [1:0]           pc_sel,
    output logic                 pc_we,
    output logic                 ifid_we,
    output logic                 ifid_flush,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);

    localparam int unsigned FCW = 3;
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(1);

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_RS1 = 2'd3;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [FCW-1:0] fcnt;
    logic [FCW-1:0] fcnt_nxt;
    logic           take;

    // State, flush counter and redirect counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HOLD;
            fcnt         <= '0;
            redirect_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (take && (redirect_cnt != {CNT_WIDTH{1'b1}})) begin
                redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and Mealy outputs; redirect actions are shared via take
    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        pc_sel     = SEL_SEQ;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        take       = 1'b0;

        case (state)
            HOLD: begin
                ifid_flush = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                if (branch) begin
                    pc_sel = SEL_RS1;
                    take   = 1'b1;
                end else if (jump_m) begin
                    if (mem_ready) begin
                        pc_sel = SEL_MEM;
                        take   = 1'b1;
                    end else begin
                        state_nxt = MEMWAIT;
                    end
                end else if (jump) begin
                    pc_sel = SEL_ALU;
                    take   = 1'b1;
                end else if (!stall) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end
            MEMWAIT: begin
                // Only memory readiness matters; the jumping instruction is frozen
                if (mem_ready) begin
                    pc_sel = SEL_MEM;
                    take   = 1'b1;
                end
            end
            FLUSH: begin
                pc_we      = 1'b1;
                ifid_flush = 1'b1;
                if (fcnt <= FLUSH_LAST) begin
                    state_nxt = RUN;
                end else begin
                    fcnt_nxt = fcnt - FCW'(1);
                end
            end
            default: begin
                ifid_flush = 1'b1;
                state_nxt  = HOLD;
            end
        endcase

        if (take) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                fcnt_nxt  = FLUSH_INIT;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    assign busy = (state != RUN);

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboarded bench for fetch_controller (FLUSH_CYCLES=2, CNT_WIDTH=4).
module tb_fetch_controller;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          branch = 1'b0;
    logic          jump_m = 1'b0;
    logic          jump = 1'b0;
    logic          stall = 1'b0;
    logic          mem_ready = 1'b0;
    logic [1:0]    pc_sel;
    logic          pc_we;
    logic          ifid_we;
    logic          ifid_flush;
    logic          busy;
    logic [CW-1:0] redirect_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];

    fetch_controller #(.FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .branch(branch), .jump_m(jump_m), .jump(jump),
        .stall(stall), .mem_ready(mem_ready), .pc_sel(pc_sel), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .busy(busy),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    // Expected output word: {pc_sel, pc_we, ifid_we, ifid_flush, busy, redirect_cnt}
    function automatic logic [9:0] ev(input int sel, input bit we, input bit iwe,
                                      input bit fl, input bit bsy, input int cnt);
        return {2'(sel), we, iwe, fl, bsy, CW'(cnt)};
    endfunction

    function automatic logic [9:0] got_word();
        return {pc_sel, pc_we, ifid_we, ifid_flush, busy, redirect_cnt};
    endfunction

    // Apply one cycle of stimulus {branch,jump_m,jump,stall,mem_ready} and queue its expectation
    task automatic drive_cycle(input logic r, input logic [4:0] s, input logic [9:0] e);
        @(posedge clk);
        #1;
        rst = r;
        {branch, jump_m, jump, stall, mem_ready} = s;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [4:0] stim [7] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
        logic       rv   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [9:0] ex   [7];
        logic [9:0] e;
        for (int i = 0; i < 4; i++) ex[i] = ev(0, 0, 0, 1, 1, 0);
        for (int i = 4; i < 7; i++) ex[i] = ev(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            drive_cycle(rv[i], stim[i], ex[i]);
            #3;
            e = exp_q.pop_front();
            vectors++;
            if (got_word() !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %b expected %b", i, got_word(), e);
            end
        end
    endtask

    task automatic test_priority();
        logic [4:0] stim [8] = '{5'b11101, 5'b00000, 5'b00000, 5'b01101,
                                 5'b10000, 5'b00110, 5'b00000, 5'b00000};
        logic [9:0] ex   [8];
        logic [9:0] e;
        ex[0] = ev(3, 1, 0, 1, 0, 0);
        ex[1] = ev(0, 1, 0, 1, 1, 1);
        ex[2] = ev(0, 1, 1, 0, 0, 1);
        ex[3] = ev(2, 1, 0, 1, 0, 1);
        ex[4] = ev(0, 1, 0, 1, 1, 2);
        ex[5] = ev(1, 1, 0, 1, 0, 2);
        ex[6] = ev(0, 1, 0, 1, 1, 3);
        ex[7] = ev(0, 1, 1, 0, 0, 3);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, stim[i], ex[i]);
            #3;
            e = exp_q.pop_front();
            vectors++;
            if (got_word() !== e) begin
                miscompares++;
                $display("FAIL priority[%0d]: got %b expected %b", i, got_word(), e);
            end
        end
    endtask

    task automatic test_memwait();
        logic [4:0] stim [6] = '{5'b01000, 5'b01010, 5'b11000, 5'b01001, 5'b00000, 5'b00000};
        logic [9:0] ex   [6];
        logic [9:0] e;
        ex[0] = ev(0, 0, 0, 0, 0, 3);
        ex[1] = ev(0, 0, 0, 0, 1, 3);
        ex[2] = ev(0, 0, 0, 0, 1, 3);
        ex[3] = ev(2, 1, 0, 1, 1, 3);
        ex[4] = ev(0, 1, 0, 1, 1, 4);
        ex[5] = ev(0, 1, 1, 0, 0, 4);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, stim[i], ex[i]);
            #3;
            e = exp_q.pop_front();
            vectors++;
            if (got_word() !== e) begin
                miscompares++;
                $display("FAIL memwait[%0d]: got %b expected %b", i, got_word(), e);
            end
        end
    endtask

    task automatic test_stall();
        logic [4:0] stim [3] = '{5'b00010, 5'b00010, 5'b00000};
        logic [9:0] ex   [3];
        logic [9:0] e;
        ex[0] = ev(0, 0, 0, 0, 0, 4);
        ex[1] = ev(0, 0, 0, 0, 0, 4);
        ex[2] = ev(0, 1, 1, 0, 0, 4);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, stim[i], ex[i]);
            #3;
            e = exp_q.pop_front();
            vectors++;
            if (got_word() !== e) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %b expected %b", i, got_word(), e);
            end
        end
    endtask

    task automatic test_reset_mid_memwait();
        logic [9:0] e;
        drive_cycle(1'b0, 5'b01000, ev(0, 0, 0, 0, 0, 4));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL midrst_enter: got %b expected %b", got_word(), e);
        end
        drive_cycle(1'b0, 5'b00000, ev(0, 0, 0, 0, 1, 4));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL midrst_wait: got %b expected %b", got_word(), e);
        end
        // Asynchronous assertion between clock edges
        #1;
        rst = 1'b1;
        exp_q.push_back(ev(0, 0, 0, 1, 1, 0));
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL midrst_async: got %b expected %b", got_word(), e);
        end
        drive_cycle(1'b1, 5'b01001, ev(0, 0, 0, 1, 1, 0));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL midrst_held: got %b expected %b", got_word(), e);
        end
        drive_cycle(1'b0, 5'b00000, ev(0, 0, 0, 1, 1, 0));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL midrst_hold: got %b expected %b", got_word(), e);
        end
        drive_cycle(1'b0, 5'b00000, ev(0, 1, 1, 0, 0, 0));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL midrst_run: got %b expected %b", got_word(), e);
        end
    endtask

    task automatic test_saturation();
        logic [9:0] e;
        int         cnt = 0;
        for (int k = 0; k < 20; k++) begin
            drive_cycle(1'b0, 5'b00100, ev(1, 1, 0, 1, 0, cnt));
            #3;
            e = exp_q.pop_front();
            vectors++;
            if (got_word() !== e) begin
                miscompares++;
                $display("FAIL sat_jump[%0d]: got %b expected %b", k, got_word(), e);
            end
            if (cnt < 15) cnt++;
            drive_cycle(1'b0, 5'b00000, ev(0, 1, 0, 1, 1, cnt));
            #3;
            e = exp_q.pop_front();
            vectors++;
            if (got_word() !== e) begin
                miscompares++;
                $display("FAIL sat_flush[%0d]: got %b expected %b", k, got_word(), e);
            end
        end
        drive_cycle(1'b0, 5'b00000, ev(0, 1, 1, 0, 0, 15));
        #3;
        e = exp_q.pop_front();
        vectors++;
        if (got_word() !== e) begin
            miscompares++;
            $display("FAIL sat_final: got %b expected %b", got_word(), e);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_memwait();
        test_stall();
        test_reset_mid_memwait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
